// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the system-ID slave.
interface sysid_boot_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/sysid_boot_checker.sv
// Reads the sysid ID and timestamp words, compares them with build-time constants
// and holds a sticky pass/fail verdict that gates game start.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1495875509,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    sysid_boot_checker_if.master        avm,
    output logic                        busy,
    output logic                        done,
    output logic                        sys_ok,
    output logic                        id_mismatch,
    output logic                        ts_mismatch,
    output logic                        timeout_err,
    output logic [31:0]                 id_value,
    output logic [31:0]                 ts_value
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_EVAL,
        ST_FINISH
    } state_t;

    state_t      state_reg,       state_next;
    logic        auto_reg,        auto_next;
    logic [15:0] wait_cnt_reg,    wait_cnt_next;
    logic        sys_ok_reg,      sys_ok_next;
    logic        id_mismatch_reg, id_mismatch_next;
    logic        ts_mismatch_reg, ts_mismatch_next;
    logic        timeout_reg,     timeout_next;
    logic [31:0] id_value_reg,    id_value_next;
    logic [31:0] ts_value_reg,    ts_value_next;

    logic        limit_hit;
    logic        id_diff;
    logic        ts_diff;

    assign limit_hit = (wait_cnt_reg == TIMEOUT_LIMIT);
    assign id_diff   = (id_value_reg != EXPECTED_ID);
    assign ts_diff   = CHECK_TIMESTAMP && (ts_value_reg != EXPECTED_TIMESTAMP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            auto_reg        <= AUTO_START;
            wait_cnt_reg    <= '0;
            sys_ok_reg      <= 1'b0;
            id_mismatch_reg <= 1'b0;
            ts_mismatch_reg <= 1'b0;
            timeout_reg     <= 1'b0;
            id_value_reg    <= '0;
            ts_value_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            auto_reg        <= auto_next;
            wait_cnt_reg    <= wait_cnt_next;
            sys_ok_reg      <= sys_ok_next;
            id_mismatch_reg <= id_mismatch_next;
            ts_mismatch_reg <= ts_mismatch_next;
            timeout_reg     <= timeout_next;
            id_value_reg    <= id_value_next;
            ts_value_reg    <= ts_value_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        // The auto-start request only lives for the first cycle after reset.
        auto_next        = 1'b0;
        wait_cnt_next    = wait_cnt_reg;
        sys_ok_next      = sys_ok_reg;
        id_mismatch_next = id_mismatch_reg;
        ts_mismatch_next = ts_mismatch_reg;
        timeout_next     = timeout_reg;
        id_value_next    = id_value_reg;
        ts_value_next    = ts_value_reg;
        avm.avm_read     = 1'b0;
        avm.avm_address  = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start || auto_reg) begin
                    state_next       = ST_RD_ID;
                    wait_cnt_next    = '0;
                    sys_ok_next      = 1'b0;
                    id_mismatch_next = 1'b0;
                    ts_mismatch_next = 1'b0;
                    timeout_next     = 1'b0;
                end
            end

            ST_RD_ID: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = 1'b0;
                // Acceptance is tested first so a late answer on the limit cycle still counts.
                if (!avm.avm_waitrequest) begin
                    id_value_next = avm.avm_readdata;
                    wait_cnt_next = '0;
                    state_next    = ST_RD_TS;
                end else if (limit_hit) begin
                    timeout_next  = 1'b1;
                    state_next    = ST_FINISH;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end

            ST_RD_TS: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = 1'b1;
                if (!avm.avm_waitrequest) begin
                    ts_value_next = avm.avm_readdata;
                    state_next    = ST_EVAL;
                end else if (limit_hit) begin
                    timeout_next  = 1'b1;
                    state_next    = ST_FINISH;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end

            ST_EVAL: begin
                id_mismatch_next = id_diff;
                ts_mismatch_next = ts_diff;
                sys_ok_next      = !id_diff && !ts_diff;
                state_next       = ST_FINISH;
            end

            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign sys_ok      = sys_ok_reg;
    assign id_mismatch = id_mismatch_reg;
    assign ts_mismatch = ts_mismatch_reg;
    assign timeout_err = timeout_reg;
    assign id_value    = id_value_reg;
    assign ts_value    = ts_value_reg;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomized bench: two checkers (timestamp checked / ignored) share one scripted sysid slave
// behaviour and are compared against a latency/result model derived from the read outcomes.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1495875509;
    localparam int          TMO    = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;

    always #5 clock = ~clock;

    sysid_boot_checker_if bus0 ();
    sysid_boot_checker_if bus1 ();

    logic        busy0, done0, ok0, idm0, tsm0, tmo0;
    logic        busy1, done1, ok1, idm1, tsm1, tmo1;
    logic [31:0] idv0, tsv0, idv1, tsv1;

    sysid_boot_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .CHECK_TIMESTAMP(1'b1),
        .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
    ) u_dut0 (
        .clock(clock), .reset_n(reset_n), .start(start), .avm(bus0.master),
        .busy(busy0), .done(done0), .sys_ok(ok0), .id_mismatch(idm0), .ts_mismatch(tsm0),
        .timeout_err(tmo0), .id_value(idv0), .ts_value(tsv0)
    );

    sysid_boot_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .CHECK_TIMESTAMP(1'b0),
        .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
    ) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start), .avm(bus1.master),
        .busy(busy1), .done(done1), .sys_ok(ok1), .id_mismatch(idm1), .ts_mismatch(tsm1),
        .timeout_err(tmo1), .id_value(idv1), .ts_value(tsv1)
    );

    // Slave script: each read stalls for wait_id / wait_ts cycles, then returns its word.
    logic [31:0] word_id = 32'd0;
    logic [31:0] word_ts = 32'd1495875509;
    int          wait_id = 0;
    int          wait_ts = 0;
    int          pend0, pend1;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) pend0 <= 0;
        else if (bus0.avm_read && bus0.avm_waitrequest) pend0 <= pend0 + 1;
        else pend0 <= 0;
    end
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) pend1 <= 0;
        else if (bus1.avm_read && bus1.avm_waitrequest) pend1 <= pend1 + 1;
        else pend1 <= 0;
    end

    assign bus0.avm_waitrequest = bus0.avm_read && (pend0 < (bus0.avm_address ? wait_ts : wait_id));
    assign bus0.avm_readdata    = bus0.avm_address ? word_ts : word_id;
    assign bus1.avm_waitrequest = bus1.avm_read && (pend1 < (bus1.avm_address ? wait_ts : wait_id));
    assign bus1.avm_readdata    = bus1.avm_address ? word_ts : word_id;

    int          total = 0;
    int          bad   = 0;
    int          txn   = 0;
    logic [31:0] prev_id = 32'd0;
    logic [31:0] prev_ts = 32'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_busy"},  {31'd0, busy0 | busy1}, 32'd0);
        check_val({tag, "_done"},  {31'd0, done0 | done1}, 32'd0);
        check_val({tag, "_ok"},    {31'd0, ok0 | ok1}, 32'd0);
        check_val({tag, "_flags"}, {28'd0, idm0 | idm1, tsm0 | tsm1, tmo0, tmo1}, 32'd0);
        check_val({tag, "_idv"},   idv0 | idv1, 32'd0);
        check_val({tag, "_tsv"},   tsv0 | tsv1, 32'd0);
        check_val({tag, "_read"},  {31'd0, bus0.avm_read | bus1.avm_read}, 32'd0);
    endtask

    // Called at a negedge. do_start=0 means the check was launched by auto-start.
    task automatic run_check(input bit do_start, input bit busy_start, input bit finish_start);
        bit   id_ok, ts_ok, timed_out, exp_idm, exp_tsm0, exp_read;
        int   dur_id, dur_ts, exp_lat, k;
        logic [31:0] exp_idv, exp_tsv;
        id_ok     = (wait_id <= TMO);
        ts_ok     = (wait_ts <= TMO);
        dur_id    = id_ok ? wait_id + 1 : TMO + 1;
        dur_ts    = ts_ok ? wait_ts + 1 : TMO + 1;
        timed_out = !(id_ok && ts_ok);
        exp_lat   = !id_ok ? dur_id + 1 : (ts_ok ? dur_id + dur_ts + 2 : dur_id + dur_ts + 1);
        exp_idv   = id_ok ? word_id : prev_id;
        exp_tsv   = (id_ok && ts_ok) ? word_ts : prev_ts;
        exp_idm   = !timed_out && (word_id != EXP_ID);
        exp_tsm0  = !timed_out && (word_ts != EXP_TS);

        start = do_start;
        @(posedge clock); @(negedge clock);
        start = 1'b0;
        k = 1;
        while (!done0 && k < 64) begin
            exp_read = (k <= dur_id) || (id_ok && k <= dur_id + dur_ts);
            check_val("bus_read", {31'd0, bus0.avm_read}, {31'd0, exp_read});
            if (exp_read)
                check_val("bus_addr", {31'd0, bus0.avm_address}, {31'd0, k > dur_id});
            check_val("busy", {31'd0, busy0}, 32'd1);
            start = busy_start && (k == 2);
            @(posedge clock); @(negedge clock);
            k++;
        end
        start = 1'b0;
        check_val("latency", 32'(k), 32'(exp_lat));
        check_val("done1", {31'd0, done1}, 32'd1);
        check_val("tmo0", {31'd0, tmo0}, {31'd0, timed_out});
        check_val("tmo1", {31'd0, tmo1}, {31'd0, timed_out});
        check_val("idm0", {31'd0, idm0}, {31'd0, exp_idm});
        check_val("idm1", {31'd0, idm1}, {31'd0, exp_idm});
        check_val("tsm0", {31'd0, tsm0}, {31'd0, exp_tsm0});
        check_val("tsm1", {31'd0, tsm1}, 32'd0);
        check_val("ok0", {31'd0, ok0}, {31'd0, !timed_out && !exp_idm && !exp_tsm0});
        check_val("ok1", {31'd0, ok1}, {31'd0, !timed_out && !exp_idm});
        check_val("idv0", idv0, exp_idv);
        check_val("tsv0", tsv0, exp_tsv);
        check_val("idv1", idv1, exp_idv);
        check_val("tsv1", tsv1, exp_tsv);

        start = finish_start;
        @(posedge clock); @(negedge clock);
        start = 1'b0;
        check_val("done_width", {31'd0, done0}, 32'd0);
        check_val("idle_after", {31'd0, busy0 | busy1}, 32'd0);
        @(posedge clock); @(negedge clock);
        check_val("no_restart", {31'd0, busy0 | busy1}, 32'd0);
        check_val("ok0_hold", {31'd0, ok0}, {31'd0, !timed_out && !exp_idm && !exp_tsm0});

        prev_id = exp_idv;
        prev_ts = exp_tsv;
        $display("txn %0d id=%08h ts=%08h wait_id=%0d wait_ts=%0d latency=%0d expected=%0d",
                 txn, word_id, word_ts, wait_id, wait_ts, k, exp_lat);
        txn++;
    endtask

    task automatic set_slave(input logic [31:0] id, input logic [31:0] ts, input int wi, input int wt);
        word_id = id;
        word_ts = ts;
        wait_id = wi;
        wait_ts = wt;
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 0;
        if (r < 8) return $urandom_range(1, TMO);
        return $urandom_range(TMO + 1, TMO + 4);
    endfunction

    initial begin
        logic [31:0] rid, rts;
        int          n;

        // Reset state, then the auto-started check after release.
        set_slave(EXP_ID, EXP_TS, 0, 0);
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset_n = 1'b1;
        run_check(1'b0, 1'b0, 1'b0);

        set_slave(32'd5, EXP_TS, 0, 0);           run_check(1'b1, 1'b0, 1'b0);
        set_slave(EXP_ID, EXP_TS + 32'd1, 0, 0);  run_check(1'b1, 1'b0, 1'b0);
        set_slave(EXP_ID, EXP_TS, 3, 3);          run_check(1'b1, 1'b1, 1'b1);
        set_slave(EXP_ID, EXP_TS, 0, 1000);       run_check(1'b1, 1'b0, 1'b0);
        set_slave(EXP_ID, EXP_TS, 0, 0);          run_check(1'b1, 1'b0, 1'b0);
        set_slave(EXP_ID, EXP_TS, TMO, TMO);      run_check(1'b1, 1'b0, 1'b0);
        set_slave(32'd7, EXP_TS, TMO + 1, 0);     run_check(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       rid = EXP_ID;
                1:       rid = 32'd5;
                default: rid = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0:       rts = EXP_TS;
                1:       rts = EXP_TS + 32'd1;
                default: rts = $urandom;
            endcase
            set_slave(rid, rts, pick_wait(), pick_wait());
            run_check(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of the timestamp read discards everything captured so far.
        set_slave(32'hA5A5_0001, EXP_TS, 0, 1000);
        start = 1'b1;
        @(posedge clock); @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(bus0.avm_read && bus0.avm_address) && n < 20) begin
            @(posedge clock); @(negedge clock);
            n++;
        end
        check_val("reach_rd_ts", {31'd0, bus0.avm_read && bus0.avm_address}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check_zero("midreset");
        prev_id = 32'd0;
        prev_ts = 32'd0;
        set_slave(EXP_ID, EXP_TS, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        run_check(1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
